// File: rtl/decompress_if.sv
// Coefficient-in / polynomial-out stream bundle for the Kyber decompress stage.
// Valid/ready: a word moves when valid and ready are both high at a rising edge.
interface decompress_if;
   logic [63:0] i_coeffs;
   logic        i_coeffs_valid;
   logic        o_coeffs_ready;
   logic [3:0]  i_d;
   logic [63:0] o_poly;
   logic        o_poly_valid;
   logic        i_poly_ready;
   logic        o_done;
   logic        o_err;

   modport master (
      output i_coeffs, i_coeffs_valid, i_d, i_poly_ready,
      input  o_coeffs_ready, o_poly, o_poly_valid, o_done, o_err
   );

   modport slave (
      input  i_coeffs, i_coeffs_valid, i_d, i_poly_ready,
      output o_coeffs_ready, o_poly, o_poly_valid, o_done, o_err
   );
endinterface

// File: rtl/decompress.sv
// Kyber Decompress_d: y = round(Q*x/2^d) per 16-bit lane; registers are multiply, round, output.
// Optional d=12 range check enabled by defining DECOMP_RANGE_CHK_EN (o_err tied low otherwise).
module decompress #(
   parameter int Q     = 3329,
   parameter int NLANE = 4,
   parameter int NWORD = 64
) (
   input logic         i_clk,
   input logic         i_rst,
   decompress_if.slave bus
);
   localparam int CW = $clog2(NWORD);

   logic          adv;
   logic          accept;
   logic [CW-1:0] cnt;
   logic [3:0]    d_reg;
   logic [3:0]    d_cur;
   logic [11:0]   mask;
   logic [22:0]   m_next [NLANE];
   logic          s1_valid;
   logic          s1_last;
   logic [3:0]    s1_d;
   logic [22:0]   s1_m [NLANE];
   logic [23:0]   rsum [NLANE];
   logic [11:0]   y_next [NLANE];
   logic          s2_valid;
   logic          s2_last;
   logic [11:0]   s2_y [NLANE];
   logic [63:0]   poly_q;
   logic          poly_valid_q;
   logic          done_q;
   logic          unused_hi;

   // Whole pipeline advances together; stalls only when the output word is stuck.
   assign adv    = ~poly_valid_q | bus.i_poly_ready;
   assign accept = bus.i_coeffs_valid & adv;
   assign d_cur  = (cnt == '0) ? bus.i_d : d_reg;

   assign bus.o_coeffs_ready = adv;
   assign bus.o_poly         = poly_q;
   assign bus.o_poly_valid   = poly_valid_q;
   assign bus.o_done         = done_q;

   always_comb begin
      mask = (12'd1 << d_cur) - 12'd1;
      for (int k = 0; k < NLANE; k++) begin
         m_next[k] = '0;
         if (d_cur == 4'd12)
            m_next[k] = {11'd0, bus.i_coeffs[16*k +: 12]};
         else if (d_cur >= 4'd1 && d_cur <= 4'd11)
            m_next[k] = 23'(Q) * {11'd0, bus.i_coeffs[16*k +: 12] & mask};
      end
   end

   // Adding half an LSB before the shift gives round-half-up.
   always_comb begin
      for (int k = 0; k < NLANE; k++) begin
         rsum[k]   = {1'b0, s1_m[k]} + (24'd1 << (s1_d - 4'd1));
         y_next[k] = '0;
         if (s1_d == 4'd12)
            y_next[k] = s1_m[k][11:0];
         else if (s1_d >= 4'd1 && s1_d <= 4'd11)
            y_next[k] = 12'(rsum[k] >> s1_d);
      end
   end

   always_comb begin
      unused_hi = 1'b0;
      for (int k = 0; k < NLANE; k++)
         unused_hi = unused_hi ^ (^bus.i_coeffs[16*k+12 +: 4]);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt          <= '0;
         d_reg        <= '0;
         s1_valid     <= 1'b0;
         s1_last      <= 1'b0;
         s1_d         <= '0;
         s2_valid     <= 1'b0;
         s2_last      <= 1'b0;
         poly_q       <= '0;
         poly_valid_q <= 1'b0;
         done_q       <= 1'b0;
         for (int k = 0; k < NLANE; k++) begin
            s1_m[k] <= '0;
            s2_y[k] <= '0;
         end
      end else begin
         if (accept) begin
            cnt <= (cnt == CW'(NWORD - 1)) ? '0 : cnt + CW'(1);
            if (cnt == '0)
               d_reg <= bus.i_d;
         end
         if (adv) begin
            s1_valid     <= accept;
            s1_last      <= (cnt == CW'(NWORD - 1));
            s1_d         <= d_cur;
            s2_valid     <= s1_valid;
            s2_last      <= s1_last;
            poly_valid_q <= s2_valid;
            done_q       <= s2_valid & s2_last;
            for (int k = 0; k < NLANE; k++) begin
               s1_m[k]             <= m_next[k];
               s2_y[k]             <= y_next[k];
               poly_q[16*k +: 16]  <= {4'd0, s2_y[k]};
            end
         end
      end
   end

`ifdef DECOMP_RANGE_CHK_EN
   logic rng_next;
   logic s1_rng;
   logic s2_rng;
   logic err_q;

   always_comb begin
      rng_next = 1'b0;
      if (d_cur == 4'd12)
         for (int k = 0; k < NLANE; k++)
            if (bus.i_coeffs[16*k +: 12] >= 12'(Q))
               rng_next = 1'b1;
   end

   // The flag rides with its word and latches as that word lands on o_poly.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_rng <= 1'b0;
         s2_rng <= 1'b0;
         err_q  <= 1'b0;
      end else if (adv) begin
         s1_rng <= accept & rng_next;
         s2_rng <= s1_valid & s1_rng;
         if (s2_valid & s2_rng)
            err_q <= 1'b1;
      end
   end

   assign bus.o_err = err_q;
`else
   assign bus.o_err = 1'b0;
`endif
endmodule

// File: tb/tb_decompress.sv
// Self-checking bench for decompress: vector table, streaming scoreboard, stall and reset sequences.
module tb_decompress;
  localparam int Q = 3329;
`ifdef DECOMP_RANGE_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [3:0]  d;
    logic [63:0] x;
    logic [63:0] y;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decompress_if bus();

  decompress dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int mdl_cnt  = 0;
  int mdl_d    = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  vec_t vecs[10];
  logic [3:0] legal_d[5] = '{4'd1, 4'd4, 4'd5, 4'd10, 4'd11};

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_lane(input logic [15:0] x, input int d);
    int xm;
    if (d == 12) return {4'd0, x[11:0]};
    if (d < 1 || d > 11) return 16'd0;
    xm = int'(x) % (1 << d);
    // round(a/b) with halves rounded up = floor((2a + b) / 2b)
    return 16'((2 * Q * xm + (1 << d)) / (1 << (d + 1)));
  endfunction

  function automatic logic [63:0] ref_word(input logic [63:0] x, input int d);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[16*k +: 16] = ref_lane(x[16*k +: 16], d);
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      if (bus.o_poly_valid && bus.i_poly_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", bus.o_poly);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream_poly", bus.o_poly, mon_e[63:0]);
          check("stream_done", 64'(bus.o_done), 64'(mon_e[64]));
        end
        if (bus.o_done) done_cnt++;
      end
      if (bus.i_coeffs_valid && bus.o_coeffs_ready) begin
        if (mdl_cnt == 0) mdl_d = int'(bus.i_d);
        exp_q.push_back({mdl_cnt == 63, ref_word(bus.i_coeffs, mdl_d)});
        mdl_cnt = (mdl_cnt + 1) % 64;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_coeffs_valid = 1'b0;
    bus.i_poly_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic stream(input int n, input logic [3:0] d_first, input int vpct, input int rpct);
    int sent = 0;
    int guard = 0;
    logic acc;
    while (sent < n && guard < 5000) begin
      bus.i_coeffs_valid = ($urandom_range(99) < vpct);
      bus.i_coeffs = {$urandom, $urandom};
      bus.i_d = (sent % 64 == 0) ? d_first : 4'($urandom_range(15));
      bus.i_poly_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      acc = bus.i_coeffs_valid && bus.o_coeffs_ready;
      tick();
      if (acc) sent++;
      guard++;
    end
    bus.i_coeffs_valid = 1'b0;
    if (sent < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL stream_timeout: got %0d words expected %0d", sent, n);
    end
  endtask

  task automatic drain();
    int g = 0;
    bus.i_coeffs_valid = 1'b0;
    bus.i_poly_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.o_poly_valid) && g < 50) begin
      tick();
      g++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int sent;
    logic [63:0] snap;

    vecs[0] = '{4'd1,  {16'd1, 16'd0, 16'd1, 16'hFFFE},       {16'd1665, 16'd0, 16'd1665, 16'd0},    1'b0};
    vecs[1] = '{4'd4,  {16'd15, 16'd15, 16'd15, 16'd15},      {16'd3121, 16'd3121, 16'd3121, 16'd3121}, 1'b0};
    vecs[2] = '{4'd5,  {16'd16, 16'd16, 16'd31, 16'd0},       {16'd1665, 16'd1665, 16'd3225, 16'd0}, 1'b0};
    vecs[3] = '{4'd10, {16'd1023, 16'd0, 16'd512, 16'd1},     {16'd3326, 16'd0, 16'd1665, 16'd3},    1'b0};
    vecs[4] = '{4'd11, {16'd2047, 16'hF801, 16'd0, 16'd1024}, {16'd3327, 16'd2, 16'd0, 16'd1665},    1'b0};
    vecs[5] = '{4'd12, {16'd3328, 16'hFD00, 16'd0, 16'd1},    {16'd3328, 16'd3328, 16'd0, 16'd1},    1'b0};
    vecs[6] = '{4'd0,  {4{16'hFFFF}},                         64'd0,                                 1'b0};
    vecs[7] = '{4'd13, {4{16'hFFFF}},                         64'd0,                                 1'b0};
    vecs[8] = '{4'd15, {16'h1234, 16'h0ABC, 16'h0001, 16'h07FF}, 64'd0,                              1'b0};
    vecs[9] = '{4'd12, {16'd0, 16'd3329, 16'd0, 16'd0},       {16'd0, 16'd3329, 16'd0, 16'd0},       ERR_EXP};

    bus.i_coeffs = '0;
    bus.i_coeffs_valid = 1'b0;
    bus.i_d = '0;
    bus.i_poly_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_poly",  bus.o_poly, 64'd0);
    check("rst_valid", 64'(bus.o_poly_valid), 64'd0);
    check("rst_done",  64'(bus.o_done), 64'd0);
    check("rst_err",   64'(bus.o_err), 64'd0);

    // single-word vectors, each as the first word of a fresh polynomial
    for (int i = 0; i < 10; i++) begin
      do_reset();
      bus.i_d = vecs[i].d;
      bus.i_coeffs = vecs[i].x;
      bus.i_coeffs_valid = 1'b1;
      tick();
      bus.i_coeffs_valid = 1'b0;
      bus.i_d = ~vecs[i].d;
      tick();
      check($sformatf("vec%0d_early_valid", i), 64'(bus.o_poly_valid), 64'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(bus.o_poly_valid), 64'd1);
      check($sformatf("vec%0d_poly", i),  bus.o_poly, vecs[i].y);
      check($sformatf("vec%0d_done", i),  64'(bus.o_done), 64'd0);
      check($sformatf("vec%0d_err", i),   64'(bus.o_err), 64'(vecs[i].err));
    end

    // two back-to-back polynomials, d 4 then 10, full throughput
    do_reset();
    done_cnt = 0;
    stream(64, 4'd4, 100, 100);
    stream(64, 4'd10, 100, 100);
    drain();
    check("b2b_done_cnt", 64'(done_cnt), 64'd2);
    check("b2b_err", 64'(bus.o_err), 64'd0);

    // 5-cycle output stall mid-stream
    do_reset();
    done_cnt = 0;
    sent = 0;
    snap = '0;
    for (int c = 0; c < 300 && sent < 64; c++) begin
      bus.i_coeffs_valid = 1'b1;
      bus.i_coeffs = {$urandom, $urandom};
      bus.i_d = (sent == 0) ? 4'd5 : 4'($urandom_range(15));
      bus.i_poly_ready = !(c >= 30 && c < 35);
      @(negedge clk);
      if (c == 30) snap = bus.o_poly;
      if (c >= 30 && c < 35) begin
        check("stall_ready", 64'(bus.o_coeffs_ready), 64'd0);
        check("stall_poly", bus.o_poly, snap);
      end
      if (bus.i_coeffs_valid && bus.o_coeffs_ready) sent++;
      tick();
    end
    bus.i_coeffs_valid = 1'b0;
    check("stall_sent", 64'(sent), 64'd64);
    drain();
    check("stall_done_cnt", 64'(done_cnt), 64'd1);

    // random valid/ready on both sides
    do_reset();
    done_cnt = 0;
    stream(64, legal_d[$urandom_range(4)], 70, 60);
    stream(64, legal_d[$urandom_range(4)], 50, 80);
    drain();
    check("rand_done_cnt", 64'(done_cnt), 64'd2);

    // reset after 20 words, then a fresh polynomial
    do_reset();
    done_cnt = 0;
    stream(20, 4'd4, 100, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_poly",  bus.o_poly, 64'd0);
    check("midrst_valid", 64'(bus.o_poly_valid), 64'd0);
    check("midrst_done",  64'(bus.o_done), 64'd0);
    check("midrst_err",   64'(bus.o_err), 64'd0);
    for (int c = 0; c < 4; c++) tick();
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    stream(64, 4'd5, 100, 100);
    drain();
    check("midrst_fresh_done", 64'(done_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
